rv_g_wb_arbiter: RTL and testbench
==================================

Name: rv_g_wb_arbiter

Overview:
- Write-back collector for the rv_g register file. It is the producer end of the regfile write port (wr_addr/wr_data/wr_en), which also releases the scoreboard lock on the destination.
- Takes completed results from NUM_SRC execution units over valid/ready handshakes and buffers one result per source.
- Picks one result per cycle by round-robin, formats it to MaxLen bits, and drives a registered single-cycle write to the regfile.

Parameters:
- XLEN, 64, integer register width (32 or 64)
- FLEN, 64, float register width (32 or 64)
- NUM_SRC, 4, number of execution-unit result sources (2..8)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- arst_i  in  1  asynchronous reset, active high
- src_addr_i  in  NUM_SRC x 6  destination per source; 0..31 = x-regs, 32..63 = f-regs
- src_data_i  in  NUM_SRC x MaxLen  result per source; MaxLen = max(XLEN, FLEN)
- src_valid_i  in  NUM_SRC  result present
- src_ready_o  out  NUM_SRC  result accepted when valid and ready are both high at a clock edge
- wr_addr_o  out  6  to regfile wr_addr_i
- wr_data_o  out  MaxLen  to regfile wr_data_i
- wr_en_o  out  1  to regfile wr_en_i
- busy_o  out  1  any buffer occupied or wr_en_o high

Behaviour:
- Reset (async, arst_i=1):
  - all buffer valid bits = 0; round-robin pointer = 0.
  - wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0; src_ready_o = all 1; busy_o = 0.
- Per-source buffer: one entry per source holding {valid, addr, data}.
  - Capture at an edge where src_valid_i[i] & src_ready_o[i].
- Arbitration:
  - Candidates are sources with a valid buffer.
  - grant[i] is one-hot: the first candidate at or after the pointer, wrapping NUM_SRC-1 -> 0.
  - grant is a function of registers only.
- Ready rule:
  - src_ready_o[i] = ~buf_valid[i] | grant[i].
  - No combinational path from any src_*_i to src_ready_o.
  - A granted source may refill in the same edge, giving one result per cycle per source.
- Pointer update: on an edge with any grant, pointer <= (granted index + 1) mod NUM_SRC. With no grant the pointer holds.
- Output stage:
  - On every edge: wr_en_o <= |grant & (granted addr != 0); wr_addr_o <= granted addr; wr_data_o <= formatted data.
  - With no grant: wr_en_o <= 0; addr and data hold their previous values.
- Address 0 (x0): the entry is consumed and its buffer freed, but wr_en_o stays 0.
- Latency: accept at edge k -> earliest wr_en_o high in the cycle after edge k+1 (2 edges). Throughput is 1 write per cycle aggregate.
- Width and format rules:
  - addr < 32 and XLEN < MaxLen: data[MaxLen-1:XLEN] forced to 0.
  - addr >= 32 and FLEN < MaxLen: data[MaxLen-1:FLEN] forced to all ones (NaN-box).
  - Otherwise data passes unchanged.
- Simultaneous events:
  - Freeing and refilling the same buffer at one edge: the new entry is stored.
  - Two sources with the same addr: written in grant order, with no merging.
- Reset mid-operation: buffered results are discarded, and a write in flight is dropped (wr_en_o forced to 0 immediately).
- busy_o = |buf_valid | wr_en_o.

Decomposition:
- Shared package rv_g_pkg holds:
  - REG_ADDR_W = 6 and FREG_BASE = 32;
  - the MaxLen helper function;
  - typedef wb_req_t {addr, data}.
- Sub-module rv_g_rr_arbiter (NUM_REQ parameter): request vector plus registered pointer -> one-hot grant and grant index, with a pointer-advance input. It is reused by the issue logic.

Test Plan:
- Reset idle: arst_i pulse, no valid -> src_ready_o=all 1, wr_en_o=0, busy_o=0 for 20 cycles.
- Single write: source 1 addr=5, data=0x1234 valid 1 cycle -> exactly one cycle of wr_en_o=1, wr_addr_o=5, wr_data_o=0x1234, 2 edges after accept.
- Round-robin fairness: all 4 sources valid continuously, pointer=0 -> grant order 0,1,2,3,0,...; each source gets 1 of every 4 writes; wr_en_o stays 1 every cycle.
- x0 drop: source 0 addr=0, data=0xFFFF -> src_ready_o handshake completes, wr_en_o stays 0, and the buffer frees next edge.
- NaN-box/zero-extend (XLEN=64, FLEN=32):
  - addr=40, data=0x3F800000 -> wr_data_o=0xFFFFFFFF3F800000.
  - XLEN=32, FLEN=64: addr=3, data=0xAAAAAAAA_12345678 -> 0x00000000_12345678.
- Reset mid-flight: 3 buffers full, arst_i asserted asynchronously between edges -> wr_en_o=0 immediately, busy_o=0, and no further writes after release.
- Randomized: compare against a DPI reference model that replays write order, and check that every lock the regfile sets is released exactly once.

Source files
------------

// File: rtl/rv_g_pkg.sv
// Shared rv_g types and constants.
// Register-file addressing and write-back bundle shared by pipeline units.
package rv_g_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int FREG_BASE  = 32;
  localparam int DATA_W_MAX = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W_MAX-1:0] data;
  } wb_req_t;

  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rv_g_rr_arbiter.sv
// Round-robin arbiter with registered pointer.
// Grant is purely a function of the request vector and the pointer.
module rv_g_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);

  logic [IW-1:0] ptr;
  int            j;

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
        any       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && any) begin
      if (grant_idx == IW'(NUM_REQ - 1)) ptr <= '0;
      else                               ptr <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/rv_g_wb_arbiter.sv
// Write-back collector: buffers one result per unit, picks one per
// cycle round-robin, formats it and drives the regfile write port.
module rv_g_wb_arbiter
  import rv_g_pkg::*;
#(
  parameter  int XLEN    = 64,
  parameter  int FLEN    = 64,
  parameter  int NUM_SRC = 4,
  localparam int MaxLen  = max_len(XLEN, FLEN)
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_addr_i,
  input  logic [NUM_SRC-1:0][MaxLen-1:0]      src_data_i,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  output logic [REG_ADDR_W-1:0]               wr_addr_o,
  output logic [MaxLen-1:0]                   wr_data_o,
  output logic                                wr_en_o,
  output logic                                busy_o
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic [MaxLen-1:0] XKEEP = {MaxLen{1'b1}} >> (MaxLen - XLEN);
  localparam logic [MaxLen-1:0] FKEEP = {MaxLen{1'b1}} >> (MaxLen - FLEN);

  logic [NUM_SRC-1:0]                 buf_valid;
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] buf_addr;
  logic [NUM_SRC-1:0][MaxLen-1:0]     buf_data;
  logic [NUM_SRC-1:0]                 grant;
  logic [IW-1:0]                      gidx;
  logic                               any;
  logic [REG_ADDR_W-1:0]              sel_addr;
  logic [MaxLen-1:0]                  sel_data;
  logic [MaxLen-1:0]                  fmt_data;
  logic                               is_f;

  rv_g_rr_arbiter #(
    .NUM_REQ (NUM_SRC)
  ) u_rr (
    .clk       (clk_i),
    .rst       (arst_i),
    .req       (buf_valid),
    .adv       (1'b1),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any)
  );

  assign src_ready_o = ~buf_valid | grant;
  assign sel_addr    = buf_addr[gidx];
  assign sel_data    = buf_data[gidx];
  assign is_f        = sel_addr >= REG_ADDR_W'(FREG_BASE);
  // F-regs narrower than the port are NaN-boxed; x-regs zero-extended.
  assign fmt_data    = is_f ? (sel_data | ~FKEEP) : (sel_data & XKEEP);
  assign busy_o      = |buf_valid | wr_en_o;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      buf_valid <= '0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid_i[i] && src_ready_o[i]) begin
          buf_valid[i] <= 1'b1;
          buf_addr[i]  <= src_addr_i[i];
          buf_data[i]  <= src_data_i[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o <= any && (sel_addr != '0);
      if (any) begin
        wr_addr_o <= sel_addr;
        wr_data_o <= fmt_data;
      end
    end
  end

endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
// Directed bench for rv_g_wb_arbiter: one wide-x/narrow-f instance and
// one narrow-x/wide-f two-source instance sharing clock and reset.
module tb_rv_g_wb_arbiter;
  import rv_g_pkg::*;

  logic clk = 1'b0;
  logic arst;

  logic [3:0][5:0]  a_addr;
  logic [3:0][63:0] a_data;
  logic [3:0]       a_valid;
  logic [3:0]       a_ready;
  logic [5:0]       a_wr_addr;
  logic [63:0]      a_wr_data;
  logic             a_wr_en;
  logic             a_busy;

  logic [1:0][5:0]  b_addr;
  logic [1:0][63:0] b_data;
  logic [1:0]       b_valid;
  logic [1:0]       b_ready;
  logic [5:0]       b_wr_addr;
  logic [63:0]      b_wr_data;
  logic             b_wr_en;
  logic             b_busy;

  int tests = 0;
  int fails = 0;
  wb_req_t r;

  always #5 clk = ~clk;

  rv_g_wb_arbiter #(
    .XLEN    (64),
    .FLEN    (32),
    .NUM_SRC (4)
  ) u_a (
    .clk_i       (clk),
    .arst_i      (arst),
    .src_addr_i  (a_addr),
    .src_data_i  (a_data),
    .src_valid_i (a_valid),
    .src_ready_o (a_ready),
    .wr_addr_o   (a_wr_addr),
    .wr_data_o   (a_wr_data),
    .wr_en_o     (a_wr_en),
    .busy_o      (a_busy)
  );

  rv_g_wb_arbiter #(
    .XLEN    (32),
    .FLEN    (64),
    .NUM_SRC (2)
  ) u_b (
    .clk_i       (clk),
    .arst_i      (arst),
    .src_addr_i  (b_addr),
    .src_data_i  (b_data),
    .src_valid_i (b_valid),
    .src_ready_o (b_ready),
    .wr_addr_o   (b_wr_addr),
    .wr_data_o   (b_wr_data),
    .wr_en_o     (b_wr_en),
    .busy_o      (b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 arst = 1'b1;
    #2 arst = 1'b0;
  endtask

  initial begin
    arst    = 1'b1;
    a_addr  = '0;
    a_data  = '0;
    a_valid = '0;
    b_addr  = '0;
    b_data  = '0;
    b_valid = '0;

    #2;
    check("rst_wr_en", a_wr_en, 0);
    check("rst_wr_addr", a_wr_addr, 0);
    check("rst_wr_data", a_wr_data, 0);
    check("rst_ready", a_ready, 4'hF);
    check("rst_busy", a_busy, 0);
    check("rst_b_ready", b_ready, 2'b11);
    #21 arst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_ready", a_ready, 4'hF);
      check("idle_wr_en", a_wr_en, 0);
      check("idle_busy", a_busy, 0);
    end

    // single write from source 1
    r = '{addr: 6'd5, data: 64'h1234};
    a_addr[1]  = r.addr;
    a_data[1]  = r.data;
    a_valid[1] = 1'b1;
    step();
    a_valid = '0;
    check("sw_en0", a_wr_en, 0);
    check("sw_busy0", a_busy, 1);
    check("sw_ready0", a_ready, 4'hF);
    step();
    check("sw_en1", a_wr_en, 1);
    check("sw_addr1", a_wr_addr, 64'(r.addr));
    check("sw_data1", a_wr_data, r.data);
    step();
    check("sw_en2", a_wr_en, 0);
    check("sw_busy2", a_busy, 0);

    // round robin, all sources streaming
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      a_addr[i] = 6'(8 + i);
      a_data[i] = 64'h100 + 64'(i);
    end
    a_valid = 4'hF;
    step();
    check("rr_ready_first", a_ready, 4'b0001);
    check("rr_en_first", a_wr_en, 0);
    for (int n = 2; n < 10; n++) begin
      step();
      check("rr_en", a_wr_en, 1);
      check("rr_addr", a_wr_addr, 64'(8 + (n - 2) % 4));
      check("rr_data", a_wr_data, 64'h100 + 64'((n - 2) % 4));
      check("rr_ready", a_ready, 64'(1 << ((n - 1) % 4)));
    end
    a_valid = '0;
    pulse_reset();

    // x0 destination is consumed without a write
    a_addr[0]  = 6'd0;
    a_data[0]  = 64'hFFFF;
    a_valid[0] = 1'b1;
    step();
    a_valid = '0;
    check("x0_busy0", a_busy, 1);
    check("x0_ready0", a_ready, 4'hF);
    check("x0_en0", a_wr_en, 0);
    step();
    check("x0_en1", a_wr_en, 0);
    check("x0_busy1", a_busy, 0);
    step();
    check("x0_en2", a_wr_en, 0);

    // NaN-box and zero-extend on both instances
    a_addr[2]  = 6'd40;
    a_data[2]  = 64'h3F80_0000;
    a_addr[3]  = 6'd3;
    a_data[3]  = 64'hAAAA_AAAA_1234_5678;
    a_valid    = 4'b1100;
    b_addr[0]  = 6'd3;
    b_data[0]  = 64'hAAAA_AAAA_1234_5678;
    b_addr[1]  = 6'd33;
    b_data[1]  = 64'h5555_5555_0000_0001;
    b_valid    = 2'b11;
    step();
    a_valid = '0;
    b_valid = '0;
    step();
    check("nb_en", a_wr_en, 1);
    check("nb_addr", a_wr_addr, 40);
    check("nb_data", a_wr_data, 64'hFFFF_FFFF_3F80_0000);
    check("zx_en", b_wr_en, 1);
    check("zx_addr", b_wr_addr, 3);
    check("zx_data", b_wr_data, 64'h0000_0000_1234_5678);
    step();
    check("x64_addr", a_wr_addr, 3);
    check("x64_data", a_wr_data, 64'hAAAA_AAAA_1234_5678);
    check("f64_addr", b_wr_addr, 33);
    check("f64_data", b_wr_data, 64'h5555_5555_0000_0001);
    step();
    check("fmt_a_en_end", a_wr_en, 0);
    check("fmt_b_en_end", b_wr_en, 0);
    check("fmt_a_busy_end", a_busy, 0);
    check("fmt_b_busy_end", b_busy, 0);

    // two sources targeting the same register
    a_addr[0] = 6'd7;
    a_data[0] = 64'h1;
    a_addr[1] = 6'd7;
    a_data[1] = 64'h2;
    a_valid   = 4'b0011;
    step();
    a_valid = '0;
    step();
    check("dup_addr0", a_wr_addr, 7);
    check("dup_data0", a_wr_data, 1);
    step();
    check("dup_en1", a_wr_en, 1);
    check("dup_data1", a_wr_data, 2);
    step();
    check("dup_en2", a_wr_en, 0);

    // reset while buffers are full and a write is in flight
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      a_addr[i] = 6'(10 + i);
      a_data[i] = 64'hC0 + 64'(i);
    end
    a_valid = 4'b0111;
    step();
    a_valid = '0;
    check("mf_busy0", a_busy, 1);
    check("mf_en0", a_wr_en, 0);
    step();
    check("mf_en1", a_wr_en, 1);
    check("mf_addr1", a_wr_addr, 10);
    #2 arst = 1'b1;
    #1;
    check("mf_en_rst", a_wr_en, 0);
    check("mf_busy_rst", a_busy, 0);
    check("mf_ready_rst", a_ready, 4'hF);
    check("mf_addr_rst", a_wr_addr, 0);
    #2 arst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mf_en_after", a_wr_en, 0);
      check("mf_busy_after", a_busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
